xor_slice_identity_checker: RTL and testbench

Self-checking regression engine for the "concat-with-cancelling-XOR versus direct slice" identity class. It generalises the fixed 64-bit, bit-[38:31] compare to a parametrised width and slice window, with several identity modes. It adds an LFSR stimulus generator, a start/done handshake, fault injection, mismatch counting and first-failure capture. It sits in the simulator-regression top and is driven by the testbench or a wrapper FSM.

---
 rtl/xor_slice_identity_checker.sv | 184 ++++++++++++++++++
 tb/tb_xor_slice_identity_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/xor_slice_identity_checker.sv
// xor_slice_identity_checker
// Regression engine for the "concat with cancelling XOR versus direct slice"
// identity class. An internal Galois LFSR supplies one stimulus vector per
// cycle. Each vector runs through a two-stage compare pipeline. Mismatches
// are counted with saturation, and the first failing vector is captured.
// An optional fault injection makes the compare fail on purpose from a
// chosen vector index onward.
module xor_slice_identity_checker #(
    parameter int                WIDTH       = 64,
    parameter int                LO          = 31,
    parameter int                HI          = 38,
    parameter int                NUM_VECTORS = 1024,
    parameter logic [WIDTH-1:0]  SEED        = 64'h1,
    parameter logic [WIDTH-1:0]  POLY        = 64'hD800_0000_0000_0000,
    parameter int                CNT_W       = 16,
    parameter int unsigned       INJ_IDX     = 0,
    parameter int                IDX_W       = $clog2(NUM_VECTORS + 1)
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             inj_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             first_fail_valid,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_vec
);

    // Stop elaboration if the slice window or the run length is not meaningful.
    generate
        if (!(WIDTH > HI && HI > LO && LO >= 0)) begin : g_bad_window
            $error("xor_slice_identity_checker: need WIDTH > HI > LO >= 0");
        end
        if (NUM_VECTORS < 1) begin : g_bad_count
            $error("xor_slice_identity_checker: NUM_VECTORS must be >= 1");
        end
    endgenerate

    localparam int               SW       = HI - LO + 1;
    // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             accept;
    logic             last_vec;

    logic [WIDTH-1:0] lfsr_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       mode_q;
    logic             inj_q;

    logic [SW-1:0]    s0_slice;
    logic [SW-1:0]    s0_concat;
    logic             s0_inj_hit;
    logic             s0_mis;

    logic             s1_valid_q;
    logic             s1_mis_q;
    logic [IDX_W-1:0] s1_idx_q;
    logic [WIDTH-1:0] s1_vec_q;

    logic [CNT_W-1:0] count_q;
    logic             ff_valid_q;
    logic [IDX_W-1:0] ff_idx_q;
    logic [WIDTH-1:0] ff_vec_q;

    // Next-state logic. A start request is honoured only in IDLE or DONE.
    always_comb begin
        // NOTE: each signal written here gets a default first. Without the
        // default, a path that leaves a signal unassigned infers a latch.
        state_d  = state_q;
        accept   = 1'b0;
        last_vec = (idx_q == LAST_IDX);
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN:   if (last_vec) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register. A synchronous reset aborts any run in progress.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // flop samples values from before the edge, whatever the block order.
        if (!reset_l) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Run control: latch the configuration on accept, then step the LFSR
    // and the vector index once per RUN cycle.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            lfsr_q <= SEED_EFF;
            idx_q  <= '0;
            mode_q <= 2'd0;
            inj_q  <= 1'b0;
        end else if (accept) begin
            lfsr_q <= SEED_EFF;
            idx_q  <= '0;
            mode_q <= mode;
            inj_q  <= inj_en;
        end else if (state_q == S_RUN) begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
            idx_q  <= idx_q + 1'b1;
        end
    end

    // Stage 0: form the concat expression for the selected identity and
    // compare it with the direct slice. The XOR terms cancel on purpose, so
    // the compare can fail only when the injected fault flips bit 0.
    always_comb begin
        s0_slice   = lfsr_q[HI:LO];
        s0_inj_hit = inj_q && (32'(idx_q) >= INJ_IDX);
        unique case (mode_q)
            2'd1:    s0_concat = {lfsr_q[HI:LO+1], lfsr_q[LO] ^ lfsr_q[HI] ^ lfsr_q[HI]};
            2'd2:    s0_concat = {lfsr_q[HI:LO+1], 1'b1 ^ lfsr_q[LO] ^ 1'b1};
            default: s0_concat = {lfsr_q[HI:LO+1], lfsr_q[HI] ^ lfsr_q[LO] ^ lfsr_q[HI]};
        endcase
        if (s0_inj_hit) s0_concat[0] = ~s0_concat[0];
        // Mode 3 checks the same identity with the operands swapped.
        if (mode_q == 2'd3) s0_mis = (s0_slice != s0_concat);
        else                s0_mis = (s0_concat != s0_slice);
    end

    // Stage-0 result register. It carries the vector and its index into stage 1.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            s1_valid_q <= 1'b0;
            s1_mis_q   <= 1'b0;
            s1_idx_q   <= '0;
            s1_vec_q   <= '0;
        end else begin
            s1_valid_q <= (state_q == S_RUN);
            s1_mis_q   <= s0_mis;
            s1_idx_q   <= idx_q;
            s1_vec_q   <= lfsr_q;
        end
    end

    // Stage 1: saturating mismatch count plus first-failure capture. Both are
    // cleared when a new run is accepted.
    always_ff @(posedge clk) begin
        if (!reset_l || accept) begin
            count_q    <= '0;
            ff_valid_q <= 1'b0;
            ff_idx_q   <= '0;
            ff_vec_q   <= '0;
        end else if (s1_valid_q && s1_mis_q) begin
            if (count_q != '1) count_q <= count_q + 1'b1;
            if (!ff_valid_q) begin
                ff_valid_q <= 1'b1;
                ff_idx_q   <= s1_idx_q;
                ff_vec_q   <= s1_vec_q;
            end
        end
    end

    assign busy             = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done             = (state_q == S_DONE);
    assign pass             = done && (count_q == '0);
    assign mismatch_count   = count_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_idx   = ff_idx_q;
    assign first_fail_vec   = ff_vec_q;

endmodule

// File: tb/tb_xor_slice_identity_checker.sv
// tb_xor_slice_identity_checker
// Four builds of the checker share one stimulus stream. The builds differ in
// window placement, counter width and injection index. For each run, the
// expected per-build results come from a bench-side LFSR and identity model.
// They are queued when the run is started and compared once done is observed.
module tb_xor_slice_identity_checker;

    localparam int NV = 16;

    logic       clk = 1'b0;
    logic       reset_l;
    logic       start;
    logic [1:0] mode;
    logic       inj_en;

    always #5 clk = ~clk;

    // Build A: default window, injection from vector 5.
    logic a_busy, a_done, a_pass, a_ffv;
    logic [15:0] a_cnt; logic [4:0] a_idx; logic [63:0] a_vec;
    // Build B: 3-bit counter, injection from vector 0, so the count saturates.
    logic b_busy, b_done, b_pass, b_ffv;
    logic [2:0] b_cnt; logic [4:0] b_idx; logic [63:0] b_vec;
    // Build C: 16-bit vector, full-width window HI=WIDTH-1, LO=0.
    logic c_busy, c_done, c_pass, c_ffv;
    logic [7:0] c_cnt; logic [4:0] c_idx; logic [15:0] c_vec;
    // Build D: two-bit window HI=LO+1, zero seed, injection on the last vector.
    logic d_busy, d_done, d_pass, d_ffv;
    logic [3:0] d_cnt; logic [4:0] d_idx; logic [63:0] d_vec;

    xor_slice_identity_checker #(.WIDTH(64), .LO(31), .HI(38), .NUM_VECTORS(NV),
        .SEED(64'h1), .POLY(64'hD800_0000_0000_0000), .CNT_W(16), .INJ_IDX(5))
    u_a (.clk(clk), .reset_l(reset_l), .start(start), .mode(mode), .inj_en(inj_en),
         .busy(a_busy), .done(a_done), .pass(a_pass), .mismatch_count(a_cnt),
         .first_fail_valid(a_ffv), .first_fail_idx(a_idx), .first_fail_vec(a_vec));

    xor_slice_identity_checker #(.WIDTH(64), .LO(31), .HI(38), .NUM_VECTORS(NV),
        .SEED(64'h1), .POLY(64'hD800_0000_0000_0000), .CNT_W(3), .INJ_IDX(0))
    u_b (.clk(clk), .reset_l(reset_l), .start(start), .mode(mode), .inj_en(inj_en),
         .busy(b_busy), .done(b_done), .pass(b_pass), .mismatch_count(b_cnt),
         .first_fail_valid(b_ffv), .first_fail_idx(b_idx), .first_fail_vec(b_vec));

    xor_slice_identity_checker #(.WIDTH(16), .LO(0), .HI(15), .NUM_VECTORS(NV),
        .SEED(16'hACE1), .POLY(16'hB400), .CNT_W(8), .INJ_IDX(3))
    u_c (.clk(clk), .reset_l(reset_l), .start(start), .mode(mode), .inj_en(inj_en),
         .busy(c_busy), .done(c_done), .pass(c_pass), .mismatch_count(c_cnt),
         .first_fail_valid(c_ffv), .first_fail_idx(c_idx), .first_fail_vec(c_vec));

    xor_slice_identity_checker #(.WIDTH(64), .LO(7), .HI(8), .NUM_VECTORS(NV),
        .SEED(64'h0), .POLY(64'hD800_0000_0000_0000), .CNT_W(4), .INJ_IDX(15))
    u_d (.clk(clk), .reset_l(reset_l), .start(start), .mode(mode), .inj_en(inj_en),
         .busy(d_busy), .done(d_done), .pass(d_pass), .mismatch_count(d_cnt),
         .first_fail_valid(d_ffv), .first_fail_idx(d_idx), .first_fail_vec(d_vec));

    logic [3:0]  busy_v, done_v, pass_v, ffv_v;
    logic [63:0] cnt_o [4];
    logic [63:0] idx_o [4];
    logic [63:0] vec_o [4];

    assign busy_v = {d_busy, c_busy, b_busy, a_busy};
    assign done_v = {d_done, c_done, b_done, a_done};
    assign pass_v = {d_pass, c_pass, b_pass, a_pass};
    assign ffv_v  = {d_ffv,  c_ffv,  b_ffv,  a_ffv};
    assign cnt_o[0] = 64'(a_cnt); assign idx_o[0] = 64'(a_idx); assign vec_o[0] = a_vec;
    assign cnt_o[1] = 64'(b_cnt); assign idx_o[1] = 64'(b_idx); assign vec_o[1] = b_vec;
    assign cnt_o[2] = 64'(c_cnt); assign idx_o[2] = 64'(c_idx); assign vec_o[2] = 64'(c_vec);
    assign cnt_o[3] = 64'(d_cnt); assign idx_o[3] = 64'(d_idx); assign vec_o[3] = d_vec;

    typedef struct {
        logic [63:0] cnt;
        logic        ffv;
        logic [63:0] idx;
        logic [63:0] vec;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model for one build: right-shifting Galois LFSR, then the
    // identity evaluated bit by bit, with the optional fault on concat bit 0.
    function automatic exp_t model(input int lo, input int hi, input int inj_idx,
                                   input int cnt_w, input logic [63:0] seed,
                                   input logic [63:0] poly, input logic [1:0] m,
                                   input logic inj);
        exp_t        e;
        logic [63:0] x;
        logic        b0;
        logic [63:0] sat;
        e.cnt = '0; e.ffv = 1'b0; e.idx = '0; e.vec = '0;
        sat   = (64'd1 << cnt_w) - 64'd1;
        x     = (seed == 64'd0) ? 64'd1 : seed;
        for (int i = 0; i < NV; i++) begin
            case (m)
                2'd2:    b0 = 1'b1 ^ x[lo] ^ 1'b1;
                2'd1:    b0 = x[lo] ^ x[hi] ^ x[hi];
                default: b0 = x[hi] ^ x[lo] ^ x[hi];
            endcase
            if (inj && i >= inj_idx) b0 = ~b0;
            if (b0 != x[lo]) begin
                if (e.cnt < sat) e.cnt = e.cnt + 64'd1;
                if (!e.ffv) begin
                    e.ffv = 1'b1;
                    e.idx = 64'(i);
                    e.vec = x;
                end
            end
            x = (x >> 1) ^ (x[0] ? poly : 64'd0);
        end
        return e;
    endfunction

    task automatic push_expected(input logic [1:0] m, input logic inj);
        sb.push_back(model(31, 38, 5,  16, 64'h1,    64'hD800_0000_0000_0000, m, inj));
        sb.push_back(model(31, 38, 0,  3,  64'h1,    64'hD800_0000_0000_0000, m, inj));
        sb.push_back(model(0,  15, 3,  8,  64'hACE1, 64'h0000_0000_0000_B400, m, inj));
        sb.push_back(model(7,  8,  15, 4,  64'h0,    64'hD800_0000_0000_0000, m, inj));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 64'(busy_v), 64'h0);
        check({tag, "_done"}, 64'(done_v), 64'h0);
        check({tag, "_pass"}, 64'(pass_v), 64'h0);
        check({tag, "_ffv"},  64'(ffv_v),  64'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_cnt%0d", tag, k), cnt_o[k], 64'h0);
            check($sformatf("%s_idx%0d", tag, k), idx_o[k], 64'h0);
            check($sformatf("%s_vec%0d", tag, k), vec_o[k], 64'h0);
        end
    endtask

    // One full run. Inputs change on the falling edge, so the cycle count
    // equals the distance from the accepting edge T. A nonzero pulse_at
    // raises start again in that cycle with altered mode and inj_en, and the
    // run must ignore it.
    task automatic do_run(input string tag, input logic [1:0] m, input logic inj,
                          input int pulse_at);
        int   cycles;
        logic busy_ok;
        exp_t e;
        push_expected(m, inj);
        @(negedge clk);
        start = 1'b1; mode = m; inj_en = inj;
        @(negedge clk);
        start = 1'b0; mode = ~m; inj_en = ~inj;
        cycles  = 1;
        busy_ok = 1'b1;
        check({tag, "_busy_t1"}, 64'(busy_v), 64'hF);
        check({tag, "_done_t1"}, 64'(done_v), 64'h0);
        while (done_v == 4'h0 && cycles < 200) begin
            if (busy_v != 4'hF) busy_ok = 1'b0;
            start = (cycles == pulse_at);
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check({tag, "_done_lat"}, 64'(cycles), 64'(NV + 2));
        check({tag, "_busy_span"}, 64'(busy_ok), 64'h1);
        check({tag, "_done_all"}, 64'(done_v), 64'hF);
        check({tag, "_busy_off"}, 64'(busy_v), 64'h0);
        for (int k = 0; k < 4; k++) begin
            e = sb.pop_front();
            check($sformatf("%s_cnt%0d", tag, k), cnt_o[k], e.cnt);
            check($sformatf("%s_ffv%0d", tag, k), 64'(ffv_v[k]), 64'(e.ffv));
            check($sformatf("%s_idx%0d", tag, k), idx_o[k], e.idx);
            check($sformatf("%s_vec%0d", tag, k), vec_o[k], e.vec);
            check($sformatf("%s_pass%0d", tag, k), 64'(pass_v[k]), 64'(e.cnt == 64'd0));
        end
    endtask

    initial begin
        reset_l = 1'b0; start = 1'b0; mode = 2'd0; inj_en = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        reset_l = 1'b1;

        do_run("clean_m0", 2'd0, 1'b0, 0);
        do_run("inj_m0",   2'd0, 1'b1, 0);
        do_run("clean_m1", 2'd1, 1'b0, 0);
        do_run("clean_m2", 2'd2, 1'b0, 0);
        do_run("clean_m3", 2'd3, 1'b0, 0);
        do_run("inj_m3",   2'd3, 1'b1, 0);
        do_run("inj_m1",   2'd1, 1'b1, 0);

        // start pulsed mid-RUN and in DRAIN, then restarted while done is high
        do_run("pulse_run",   2'd0, 1'b0, 5);
        do_run("pulse_drain", 2'd2, 1'b1, NV + 1);
        do_run("restart",     2'd0, 1'b0, 0);

        // reset asserted for one edge at T+8 of an injected run
        push_expected(2'd0, 1'b1);
        @(negedge clk);
        start = 1'b1; mode = 2'd0; inj_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_abort_cnt0", cnt_o[0], 64'd1);
        reset_l = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;
        check_cleared("abort");
        repeat (4) void'(sb.pop_front());
        do_run("post_abort", 2'd0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
